// File: rtl/tile_xbar_mcast_pkg.sv
// rtl/tile_xbar_mcast_pkg.sv - shared types and helpers for the multicast tile crossbar
package tile_xbar_mcast_pkg;

    localparam int N_TILES = 4;

    typedef logic [N_TILES-1:0]         tile_mask_t;
    typedef logic [$clog2(N_TILES)-1:0] tile_id_t;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_sched.sv
// rtl/rr_sched.sv - round-robin scheduler: first requester at or after the pointer wins
module rr_sched
    import tile_xbar_mcast_pkg::*;
#(
    parameter int N = N_TILES
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [N-1:0]         i_req,
    input  logic                 i_advance,
    output logic [N-1:0]         o_grant,
    output logic [$clog2(N)-1:0] o_idx,
    output logic                 o_valid
);
    localparam int IW = $clog2(N);

    logic [IW-1:0] r_ptr;
    logic [IW:0]   w_cand;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_cand  = '0;
        for (int k = 0; k < N; k++) begin
            w_cand = {1'b0, r_ptr} + (IW+1)'(k);
            if (w_cand >= (IW+1)'(N)) w_cand = w_cand - (IW+1)'(N);
            if (!o_valid && i_req[w_cand[IW-1:0]]) begin
                o_valid = 1'b1;
                o_idx   = w_cand[IW-1:0];
            end
        end
        o_grant[o_idx] = o_valid;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_ptr <= '0;
        else if (i_advance && o_valid) r_ptr <= IW'(wrap_inc(int'(o_idx), N));
    end

endmodule

// File: rtl/tile_xbar_in_fifo.sv
// rtl/tile_xbar_in_fifo.sv - per-input entry FIFO with registered ready, count and head
module tile_xbar_in_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 36
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   i_wvalid,
    output logic                   o_wready,
    input  logic [WIDTH-1:0]       i_wdata,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_head,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;
    logic [PW:0]      w_count_nxt;
    logic             r_ready;
    logic             w_push;
    logic             w_pop;

    assign w_push      = i_wvalid & r_ready;
    assign w_pop       = i_pop & (r_count != '0);
    assign w_count_nxt = r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);

    // Ready is registered from the next count, so a full FIFO never accepts in its popping cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ready  <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= w_count_nxt;
            r_ready <= (w_count_nxt != (PW+1)'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_head   = r_mem[r_rd_ptr];
    assign o_count  = r_count;
    assign o_wready = r_ready;

endmodule

// File: rtl/tile_xbar_mcast.sv
// rtl/tile_xbar_mcast.sv - NUM_SI x NUM_MI multicast task crossbar with per-input FIFOs
module tile_xbar_mcast
    import tile_xbar_mcast_pkg::*;
#(
    parameter int NUM_SI     = N_TILES,
    parameter int NUM_MI     = N_TILES,
    parameter int DATA_WIDTH = 32,
    parameter int IN_DEPTH   = 4
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic [NUM_SI-1:0]                 s_wvalid,
    output logic [NUM_SI-1:0]                 s_wready,
    input  logic [NUM_SI*DATA_WIDTH-1:0]      s_wdata,
    input  logic [NUM_SI*NUM_MI-1:0]          s_dest,
    output logic [NUM_MI-1:0]                 m_wvalid,
    input  logic [NUM_MI-1:0]                 m_wready,
    output logic [NUM_MI*DATA_WIDTH-1:0]      m_wdata,
    output logic [NUM_MI*$clog2(NUM_SI)-1:0]  m_src,
    output logic [NUM_SI-1:0]                 s_drop
);
    localparam int SW = $clog2(NUM_SI);
    localparam int EW = NUM_MI + DATA_WIDTH;
    localparam int CW = $clog2(IN_DEPTH) + 1;

    logic [DATA_WIDTH-1:0] w_head_data [NUM_SI];
    logic [NUM_MI-1:0]     w_head_dest [NUM_SI];
    logic [NUM_MI-1:0]     w_eff       [NUM_SI];
    logic [NUM_MI-1:0]     w_gnt_si    [NUM_SI];
    logic [NUM_MI-1:0]     r_served    [NUM_SI];
    logic [NUM_SI-1:0]     w_head_valid;
    logic [NUM_SI-1:0]     w_pop;

    logic [NUM_SI-1:0]     w_req       [NUM_MI];
    logic [NUM_SI-1:0]     w_rr_gnt    [NUM_MI];
    logic [SW-1:0]         w_win       [NUM_MI];
    logic [NUM_MI-1:0]     w_rr_valid;
    logic [NUM_MI-1:0]     w_can_take;
    logic [NUM_MI-1:0]     w_load;
    logic                  r_mvalid    [NUM_MI];
    logic [DATA_WIDTH-1:0] r_mdata     [NUM_MI];
    logic [SW-1:0]         r_msrc      [NUM_MI];

    for (genvar i = 0; i < NUM_SI; i++) begin : g_in
        logic [EW-1:0] w_head;
        logic [CW-1:0] w_count;

        tile_xbar_in_fifo #(.DEPTH(IN_DEPTH), .WIDTH(EW)) u_fifo (
            .clk      (clk),
            .rstn     (rstn),
            .i_wvalid (s_wvalid[i]),
            .o_wready (s_wready[i]),
            .i_wdata  ({s_dest[i*NUM_MI +: NUM_MI], s_wdata[i*DATA_WIDTH +: DATA_WIDTH]}),
            .i_pop    (w_pop[i]),
            .o_head   (w_head),
            .o_count  (w_count)
        );

        assign w_head_dest[i]  = w_head[EW-1 -: NUM_MI];
        assign w_head_data[i]  = w_head[DATA_WIDTH-1:0];
        assign w_head_valid[i] = (w_count != '0);
        assign w_eff[i]        = w_head_valid[i] ? (w_head_dest[i] & ~r_served[i]) : '0;
        // A zero-mask head satisfies this trivially, so it pops without loading any output.
        assign w_pop[i]        = w_head_valid[i] && ((r_served[i] | w_gnt_si[i]) == w_head_dest[i]);
        assign s_drop[i]       = w_head_valid[i] && (w_head_dest[i] == '0);

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn)         r_served[i] <= '0;
            else if (w_pop[i]) r_served[i] <= '0;
            else               r_served[i] <= r_served[i] | w_gnt_si[i];
        end

        for (genvar j = 0; j < NUM_MI; j++) begin : g_tr
            assign w_req[j][i]    = w_eff[i][j];
            assign w_gnt_si[i][j] = w_rr_gnt[j][i] & w_can_take[j];
        end
    end

    for (genvar j = 0; j < NUM_MI; j++) begin : g_out
        assign w_can_take[j] = !r_mvalid[j] || m_wready[j];

        rr_sched #(.N(NUM_SI)) u_rr (
            .clk       (clk),
            .rstn      (rstn),
            .i_req     (w_req[j]),
            .i_advance (w_can_take[j]),
            .o_grant   (w_rr_gnt[j]),
            .o_idx     (w_win[j]),
            .o_valid   (w_rr_valid[j])
        );

        assign w_load[j] = w_can_take[j] & w_rr_valid[j];

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                r_mvalid[j] <= 1'b0;
                r_mdata[j]  <= '0;
                r_msrc[j]   <= '0;
            end else if (w_load[j]) begin
                r_mvalid[j] <= 1'b1;
                r_mdata[j]  <= w_head_data[w_win[j]];
                r_msrc[j]   <= w_win[j];
            end else if (m_wready[j]) begin
                r_mvalid[j] <= 1'b0;
            end
        end

        assign m_wvalid[j]                        = r_mvalid[j];
        assign m_wdata[j*DATA_WIDTH +: DATA_WIDTH] = r_mdata[j];
        assign m_src[j*SW +: SW]                   = r_msrc[j];
    end

endmodule

// File: tb/tb_tile_xbar_mcast.sv
// tb/tb_tile_xbar_mcast.sv - directed self-checking bench for tile_xbar_mcast
module tb_tile_xbar_mcast;
    localparam int NS = 4;
    localparam int NM = 4;
    localparam int DW = 32;
    localparam int SW = 2;

    logic               clk = 1'b0;
    logic               rstn;
    logic [NS-1:0]      s_wvalid;
    logic [NS-1:0]      s_wready;
    logic [NS*DW-1:0]   s_wdata;
    logic [NS*NM-1:0]   s_dest;
    logic [NM-1:0]      m_wvalid;
    logic [NM-1:0]      m_wready;
    logic [NM*DW-1:0]   m_wdata;
    logic [NM*SW-1:0]   m_src;
    logic [NS-1:0]      s_drop;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int          si;
        logic [31:0] data;
        logic [3:0]  dest;
        logic [3:0]  exp_valid;
        logic [3:0]  exp_drop;
    } vec_t;

    vec_t vecs [6];

    always #5 clk = ~clk;

    tile_xbar_mcast #(.NUM_SI(NS), .NUM_MI(NM), .DATA_WIDTH(DW), .IN_DEPTH(4)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .s_wvalid (s_wvalid),
        .s_wready (s_wready),
        .s_wdata  (s_wdata),
        .s_dest   (s_dest),
        .m_wvalid (m_wvalid),
        .m_wready (m_wready),
        .m_wdata  (m_wdata),
        .m_src    (m_src),
        .s_drop   (s_drop)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input int si, input logic [31:0] data, input logic [3:0] dest);
        s_wvalid[si]          = 1'b1;
        s_wdata[si*DW +: DW]  = data;
        s_dest[si*NM +: NM]   = dest;
    endtask

    task automatic do_reset();
        rstn     = 1'b0;
        s_wvalid = '0;
        m_wready = '1;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc;
        int got;
        logic w;
        logic [31:0] exp_q [7];

        vecs[0] = '{0, 32'h0000_00A5, 4'b0010, 4'b0010, 4'b0000};
        vecs[1] = '{2, 32'h0000_0011, 4'b1111, 4'b1111, 4'b0000};
        vecs[2] = '{3, 32'hDEAD_BEEF, 4'b1000, 4'b1000, 4'b0000};
        vecs[3] = '{1, 32'h0000_0005, 4'b0101, 4'b0101, 4'b0000};
        vecs[4] = '{1, 32'h0000_0077, 4'b0000, 4'b0000, 4'b0010};
        vecs[5] = '{3, 32'h1234_5678, 4'b0110, 4'b0110, 4'b0000};

        rstn     = 1'b0;
        s_wvalid = '0;
        s_wdata  = '0;
        s_dest   = '0;
        m_wready = '1;
        repeat (2) @(negedge clk);
        check("reset s_wready", s_wready, 0);
        check("reset m_wvalid", m_wvalid, 0);
        check("reset m_src", m_src, 0);
        check("reset s_drop", s_drop, 0);
        rstn = 1'b1;
        #1 check("s_wready right after release", s_wready, 0);
        @(negedge clk);
        check("s_wready one cycle after release", s_wready, 4'hF);

        // Single-entry vectors: valid exactly two cycles after accept.
        foreach (vecs[v]) begin
            drive(vecs[v].si, vecs[v].data, vecs[v].dest);
            @(negedge clk);
            s_wvalid = '0;
            check($sformatf("vec%0d m_wvalid at t+1", v), m_wvalid, 0);
            check($sformatf("vec%0d s_drop at t+1", v), s_drop, vecs[v].exp_drop);
            @(negedge clk);
            check($sformatf("vec%0d m_wvalid at t+2", v), m_wvalid, vecs[v].exp_valid);
            check($sformatf("vec%0d s_drop at t+2", v), s_drop, 0);
            for (int j = 0; j < NM; j++) begin
                if (vecs[v].exp_valid[j]) begin
                    check($sformatf("vec%0d m_wdata[%0d]", v, j), m_wdata[j*DW +: DW], vecs[v].data);
                    check($sformatf("vec%0d m_src[%0d]", v, j), m_src[j*SW +: SW], vecs[v].si);
                end
            end
            @(negedge clk);
            check($sformatf("vec%0d m_wvalid drained", v), m_wvalid, 0);
        end

        // Partial stall: output 1 held, multicast head waits, later entry waits behind it.
        m_wready = 4'b1101;
        drive(0, 32'h22, 4'b0010);
        @(negedge clk);
        drive(0, 32'h33, 4'b0011);
        @(negedge clk);
        check("stall out1 loaded", m_wvalid, 4'b0010);
        check("stall out1 data", m_wdata[1*DW +: DW], 32'h22);
        drive(0, 32'h44, 4'b0001);
        @(negedge clk);
        s_wvalid = '0;
        check("stall mcast partial", m_wvalid, 4'b0011);
        check("stall out0 data", m_wdata[0*DW +: DW], 32'h33);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("stall hold valid %0d", k), m_wvalid, 4'b0010);
            check($sformatf("stall hold data %0d", k), m_wdata[1*DW +: DW], 32'h22);
        end
        m_wready = 4'hF;
        @(negedge clk);
        check("stall release valid", m_wvalid, 4'b0010);
        check("stall release data", m_wdata[1*DW +: DW], 32'h33);
        @(negedge clk);
        check("stall follower valid", m_wvalid, 4'b0001);
        check("stall follower data", m_wdata[0*DW +: DW], 32'h44);
        @(negedge clk);
        check("stall idle", m_wvalid, 0);

        // Round-robin contention on output 0 from a fresh pointer.
        do_reset();
        for (int i = 0; i < NS; i++) drive(i, 32'hC000_0000 | i, 4'b0001);
        @(negedge clk);
        for (int i = 0; i < NS; i++) drive(i, 32'hC000_0100 | i, 4'b0001);
        @(negedge clk);
        s_wvalid = '0;
        for (int n = 0; n < 8; n++) begin
            check($sformatf("rr valid %0d", n), m_wvalid[0], 1);
            check($sformatf("rr src %0d", n), m_src[0 +: SW], n % 4);
            check($sformatf("rr data %0d", n), m_wdata[0 +: DW], 32'hC000_0000 | ((n / 4) << 8) | (n % 4));
            @(negedge clk);
        end
        check("rr idle", m_wvalid, 0);

        // Backpressure: output 2 occupied, SI1 fills its FIFO, then drain.
        m_wready = '0;
        drive(0, 32'hB0, 4'b0100);
        @(negedge clk);
        s_wvalid = '0;
        @(negedge clk);
        check("bp blocker loaded", m_wvalid, 4'b0100);
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            drive(1, 32'hB100 + acc, 4'b0100);
            w = s_wready[1];
            @(negedge clk);
            if (w) acc++;
        end
        check("bp accepts before full", acc, 4);
        check("bp s_wready low", s_wready[1], 0);
        exp_q[0] = 32'hB0;
        for (int k = 1; k < 7; k++) exp_q[k] = 32'hB100 + k - 1;
        m_wready[2] = 1'b1;
        got = 0;
        for (int c = 0; c < 40; c++) begin
            if (m_wvalid[2]) begin
                if (got < 7) check($sformatf("bp order %0d", got), m_wdata[2*DW +: DW], exp_q[got]);
                got++;
            end
            if (acc < 6) begin
                drive(1, 32'hB100 + acc, 4'b0100);
                w = s_wready[1];
            end else begin
                s_wvalid[1] = 1'b0;
                w = 1'b0;
            end
            @(negedge clk);
            if (w) acc++;
        end
        check("bp total accepted", acc, 6);
        check("bp total delivered", got, 7);
        check("bp idle", m_wvalid, 0);

        // Reset asserted while a broadcast is stalled at the outputs.
        m_wready = '0;
        drive(2, 32'h11, 4'b1111);
        @(negedge clk);
        drive(2, 32'h12, 4'b1111);
        @(negedge clk);
        s_wvalid = '0;
        check("mid bcast valid", m_wvalid, 4'hF);
        check("mid bcast src", m_src, {4{2'd2}});
        check("mid bcast drop", s_drop, 0);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check("mid reset m_wvalid", m_wvalid, 0);
        check("mid reset s_wready", s_wready, 0);
        check("mid reset m_src", m_src, 0);
        @(negedge clk);
        rstn     = 1'b1;
        m_wready = '1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("post reset no delivery %0d", k), m_wvalid, 0);
        end
        check("post reset s_wready", s_wready, 4'hF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
